cpu_ctrl_fsm: RTL

- Multi-cycle control unit that sequences the CPU datapath and register file for one RV32I-subset instruction at a time.
- Sits between the instruction source and the datapath/register file inside `main`.
- Accepts an instruction on a valid/ready handshake, decodes it, and drives register-file read/write strobes, one-hot `dp_ctrl`, the immediate, and the external bus handshake for loads and stores.
- Pulses `done` or `illegal` on completion.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/cpu_ctrl_fsm_if.sv | 37 +++
 rtl/inst_decoder.sv | 98 +++++++++
 rtl/cpu_ctrl_fsm.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control unit.
package ctrl_pkg;

   // Major opcodes
   localparam logic [6:0] OpcLui   = 7'b0110111;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcLoad  = 7'b0000011;
   localparam logic [6:0] OpcStore = 7'b0100011;

   // funct3 values
   localparam logic [2:0] F3Add  = 3'b000;
   localparam logic [2:0] F3Xor  = 3'b100;
   localparam logic [2:0] F3Or   = 3'b110;
   localparam logic [2:0] F3And  = 3'b111;
   localparam logic [2:0] F3Srl  = 3'b101;
   localparam logic [2:0] F3Word = 3'b010;

   // funct7 values
   localparam logic [6:0] F7Zero = 7'b0000000;
   localparam logic [6:0] F7Sub  = 7'b0100000;

   // dp_ctrl one-hot bit positions
   localparam int unsigned DpAdd     = 0;
   localparam int unsigned DpSrl     = 1;
   localparam int unsigned DpSub     = 2;
   localparam int unsigned DpAnd     = 3;
   localparam int unsigned DpOr      = 4;
   localparam int unsigned DpXor     = 5;
   localparam int unsigned DpPassImm = 6;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StRead,
      StExec,
      StMem,
      StWb
   } state_e;

   typedef enum logic [2:0] {
      ClsLui,
      ClsOpImm,
      ClsOp,
      ClsLoad,
      ClsStore,
      ClsIllegal
   } inst_class_e;

   // Loads and stores go through the external bus.
   function automatic logic is_mem(inst_class_e cls);
      return (cls == ClsLoad) || (cls == ClsStore);
   endfunction

   // Classes whose datapath operand B is the immediate.
   function automatic logic uses_imm_operand(inst_class_e cls);
      return (cls == ClsOpImm) || is_mem(cls);
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction handshake, register-file strobes, datapath control and memory bus.
interface cpu_ctrl_fsm_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DP_W   = 7
);
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [ADDR_W-1:0] rf_addr1;
   logic [ADDR_W-1:0] rf_addr2;
   logic              rf_rd1;
   logic              rf_rd2;
   logic              rf_wr;
   logic [ADDR_W-1:0] rf_wr_addr;
   logic [DP_W-1:0]   dp_ctrl;
   logic              alu_src_imm;
   logic [31:0]       imm;
   logic              bus_req;
   logic              bus_we;
   logic              bus_ack;
   logic              done;
   logic              illegal;

   // Controller side
   modport master (
      input  inst_valid, inst, bus_ack,
      output inst_ready, rf_addr1, rf_addr2, rf_rd1, rf_rd2, rf_wr, rf_wr_addr,
             dp_ctrl, alu_src_imm, imm, bus_req, bus_we, done, illegal
   );

   // Instruction source / datapath / memory side
   modport slave (
      output inst_valid, inst, bus_ack,
      input  inst_ready, rf_addr1, rf_addr2, rf_rd1, rf_rd2, rf_wr, rf_wr_addr,
             dp_ctrl, alu_src_imm, imm, bus_req, bus_we, done, illegal
   );
endinterface

// File: rtl/inst_decoder.sv
// Combinational decode of one instruction word into class, ALU op, immediate and fields.
module inst_decoder
   import ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DP_W   = 7
) (
   input  logic [31:0]       inst,
   output inst_class_e       cls,
   output logic [DP_W-1:0]   dp_ctrl,
   output logic [31:0]       imm,
   output logic [ADDR_W-1:0] rs1,
   output logic [ADDR_W-1:0] rs2,
   output logic [ADDR_W-1:0] rd,
   output logic              uses_rs2,
   output logic              illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign rd     = inst[7 +: ADDR_W];
   assign rs1    = inst[15 +: ADDR_W];
   assign rs2    = inst[20 +: ADDR_W];

   // Classify the encoding and pick the datapath op and immediate format.
   always_comb begin
      cls      = ClsIllegal;
      dp_ctrl  = '0;
      imm      = '0;
      uses_rs2 = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OpcLui: begin
            cls                = ClsLui;
            dp_ctrl[DpPassImm] = 1'b1;
            imm                = {inst[31:12], 12'b0};
         end
         OpcOpImm: begin
            cls = ClsOpImm;
            imm = {{20{inst[31]}}, inst[31:20]};
            case (funct3)
               F3Add:   dp_ctrl[DpAdd] = 1'b1;
               F3Xor:   dp_ctrl[DpXor] = 1'b1;
               F3Or:    dp_ctrl[DpOr]  = 1'b1;
               F3And:   dp_ctrl[DpAnd] = 1'b1;
               F3Srl: begin
                  if (funct7 == F7Zero) dp_ctrl[DpSrl] = 1'b1;
                  else                  cls = ClsIllegal;
               end
               default: cls = ClsIllegal;
            endcase
         end
         OpcOp: begin
            cls      = ClsOp;
            uses_rs2 = 1'b1;
            if (funct3 == F3Add && funct7 == F7Sub) begin
               dp_ctrl[DpSub] = 1'b1;
            end else if (funct7 != F7Zero) begin
               cls = ClsIllegal;
            end else begin
               case (funct3)
                  F3Add:   dp_ctrl[DpAdd] = 1'b1;
                  F3Xor:   dp_ctrl[DpXor] = 1'b1;
                  F3Or:    dp_ctrl[DpOr]  = 1'b1;
                  F3And:   dp_ctrl[DpAnd] = 1'b1;
                  F3Srl:   dp_ctrl[DpSrl] = 1'b1;
                  default: cls = ClsIllegal;
               endcase
            end
         end
         OpcLoad: begin
            cls            = (funct3 == F3Word) ? ClsLoad : ClsIllegal;
            dp_ctrl[DpAdd] = 1'b1;
            imm            = {{20{inst[31]}}, inst[31:20]};
         end
         OpcStore: begin
            cls            = (funct3 == F3Word) ? ClsStore : ClsIllegal;
            dp_ctrl[DpAdd] = 1'b1;
            uses_rs2       = 1'b1;
            imm            = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         default: cls = ClsIllegal;
      endcase
      // Illegal encodings must not leak partial decode results downstream.
      if (cls == ClsIllegal) begin
         illegal  = 1'b1;
         dp_ctrl  = '0;
         imm      = '0;
         uses_rs2 = 1'b0;
      end
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: one instruction at a time through DECODE/READ/EXEC/MEM/WB.
module cpu_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DP_W        = 7,
   parameter int unsigned BUS_TIMEOUT = 15
) (
   input logic            clk,
   input logic            rst_n,
   cpu_ctrl_fsm_if.master io
);

   localparam int unsigned CntW = $clog2(BUS_TIMEOUT + 1);

   state_e            state;
   inst_class_e       cls_q;
   logic [DP_W-1:0]   dp_q;
   logic              uses_rs2_q;
   logic [CntW-1:0]   wait_cnt;

   inst_class_e       dec_cls;
   logic [DP_W-1:0]   dec_dp;
   logic [31:0]       dec_imm;
   logic [ADDR_W-1:0] dec_rs1;
   logic [ADDR_W-1:0] dec_rs2;
   logic [ADDR_W-1:0] dec_rd;
   logic              dec_uses_rs2;
   logic              dec_illegal;

   // Decoding straight off the port lets illegal show up in the DECODE cycle itself.
   inst_decoder #(
      .ADDR_W (ADDR_W),
      .DP_W   (DP_W)
   ) u_dec (
      .inst     (io.inst),
      .cls      (dec_cls),
      .dp_ctrl  (dec_dp),
      .imm      (dec_imm),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2),
      .rd       (dec_rd),
      .uses_rs2 (dec_uses_rs2),
      .illegal  (dec_illegal)
   );

   // Ready is purely a function of being idle.
   assign io.inst_ready = (state == StIdle);

   // Sequence the instruction; outputs are registered together with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= StIdle;
         cls_q          <= ClsIllegal;
         dp_q           <= '0;
         uses_rs2_q     <= 1'b0;
         wait_cnt       <= '0;
         io.rf_addr1    <= '0;
         io.rf_addr2    <= '0;
         io.rf_wr_addr  <= '0;
         io.imm         <= '0;
         io.rf_rd1      <= 1'b0;
         io.rf_rd2      <= 1'b0;
         io.rf_wr       <= 1'b0;
         io.dp_ctrl     <= '0;
         io.alu_src_imm <= 1'b0;
         io.bus_req     <= 1'b0;
         io.bus_we      <= 1'b0;
         io.done        <= 1'b0;
         io.illegal     <= 1'b0;
      end else begin
         // Strobes and pulses default low; only the owning state raises them.
         io.rf_rd1      <= 1'b0;
         io.rf_rd2      <= 1'b0;
         io.rf_wr       <= 1'b0;
         io.dp_ctrl     <= '0;
         io.alu_src_imm <= 1'b0;
         io.done        <= 1'b0;
         io.illegal     <= 1'b0;
         unique case (state)
            StIdle: begin
               if (io.inst_valid) begin
                  cls_q         <= dec_cls;
                  dp_q          <= dec_dp;
                  uses_rs2_q    <= dec_uses_rs2;
                  io.imm        <= dec_imm;
                  io.rf_addr1   <= dec_rs1;
                  io.rf_addr2   <= dec_rs2;
                  io.rf_wr_addr <= dec_rd;
                  io.illegal    <= dec_illegal;
                  state         <= StDecode;
               end
            end
            StDecode: begin
               if (cls_q == ClsIllegal) begin
                  state <= StIdle;
               end else if (cls_q == ClsLui) begin
                  io.dp_ctrl <= dp_q;
                  state      <= StExec;
               end else begin
                  io.rf_rd1 <= 1'b1;
                  io.rf_rd2 <= uses_rs2_q;
                  state     <= StRead;
               end
            end
            StRead: begin
               io.dp_ctrl     <= dp_q;
               io.alu_src_imm <= uses_imm_operand(cls_q);
               state          <= StExec;
            end
            StExec: begin
               if (is_mem(cls_q)) begin
                  io.bus_req <= 1'b1;
                  io.bus_we  <= (cls_q == ClsStore);
                  wait_cnt   <= '0;
                  state      <= StMem;
               end else begin
                  io.rf_wr <= (io.rf_wr_addr != '0);
                  io.done  <= 1'b1;
                  state    <= StWb;
               end
            end
            StMem: begin
               if (io.bus_ack) begin
                  io.bus_req <= 1'b0;
                  io.bus_we  <= 1'b0;
                  io.done    <= 1'b1;
                  if (cls_q == ClsStore) begin
                     state <= StIdle;
                  end else begin
                     io.rf_wr <= (io.rf_wr_addr != '0);
                     state    <= StWb;
                  end
               end else if (wait_cnt == CntW'(BUS_TIMEOUT - 1)) begin
                  // This unacked cycle brings the wait count to BUS_TIMEOUT: abort.
                  io.bus_req <= 1'b0;
                  io.bus_we  <= 1'b0;
                  io.illegal <= 1'b1;
                  state      <= StIdle;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StWb: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
